// File: rtl/video_cfg_pkg.sv
// Shared types and constants for the video configuration / core reset controller.
package video_cfg_pkg;

   typedef enum logic [1:0] {IDLE, WAIT_VS, SETTLE} state_t;

   localparam logic [1:0] SL_OFF = 2'b00;
   localparam logic [1:0] SL_25  = 2'b01;
   localparam logic [1:0] SL_50  = 2'b10;
   localparam logic [1:0] SL_75  = 2'b11;

endpackage

// File: rtl/video_cfg_ctrl_sync_rise.sv
// Two-flop synchronizer with a registered rising-edge pulse; level is the synchronized input.
module sync_rise (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic level,
   output logic rise
);

   logic s1, s3;

   always_ff @(posedge clk) begin
      if (reset) begin
         s1    <= 1'b0;
         level <= 1'b0;
         s3    <= 1'b0;
         rise  <= 1'b0;
      end else begin
         s1    <= d;
         level <= s1;
         s3    <= level;
         rise  <= level & ~s3;
      end
   end

endmodule

// File: rtl/video_cfg_ctrl.sv
// Frame-aligned scandoubler/scanline control with post-switch blanking and a stretched core reset.
module video_cfg_ctrl
   import video_cfg_pkg::*;
#(
   parameter logic SD_INIT       = 1'b0,
   parameter int   SETTLE_FRAMES = 8,
   parameter int   RST_HOLD      = 24,
   parameter int   VS_TIMEOUT    = 1048576
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       change_sd_i,
   input  logic       change_sl_i,
   input  logic       reset_req_i,
   input  logic       vsync_i,
   output logic       scandoubler_disable_o,
   output logic [1:0] scanlines_o,
   output logic       blank_o,
   output logic       core_reset_o,
   output logic       busy_o
);

   localparam int NUM_IN = 4;
   localparam int TW     = $clog2(VS_TIMEOUT + 1);

   // Lane order: 0 sd, 1 sl, 2 reset request, 3 vsync
   logic [NUM_IN-1:0] raw, lvl, rise;
   assign raw = {vsync_i, reset_req_i, change_sl_i, change_sd_i};

   for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_sync
      sync_rise u_sync (
         .clk   (clk_sys),
         .reset (reset),
         .d     (raw[gi]),
         .level (lvl[gi]),
         .rise  (rise[gi])
      );
   end

   logic unused_sync;
   assign unused_sync = ^{lvl[3], lvl[1:0], rise[2]};

   logic          sd_ev, sl_ev, vs_ev, req_lvl;
   assign sd_ev   = rise[0];
   assign sl_ev   = rise[1];
   assign req_lvl = lvl[2];
   assign vs_ev   = rise[3];

   state_t        state;
   logic          sd_pend;
   logic [1:0]    sl_delta, sl_reg;
   logic [TW-1:0] to_cnt;
   logic [7:0]    frame_cnt;
   logic [15:0]   hold_cnt;
   logic          pend_any, apply;

   assign pend_any = sd_pend || (sl_delta != 2'b00);
   assign apply    = (state == WAIT_VS) && (vs_ev || (to_cnt == TW'(VS_TIMEOUT - 1)));
   assign busy_o   = (state != IDLE);

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state                 <= IDLE;
         sd_pend               <= 1'b0;
         sl_delta              <= 2'b00;
         to_cnt                <= '0;
         frame_cnt             <= 8'd0;
         sl_reg                <= SL_OFF;
         scandoubler_disable_o <= SD_INIT;
         scanlines_o           <= SL_OFF;
         blank_o               <= 1'b0;
      end else begin
         // Pending state is cleared on apply before this cycle's event lands, so nothing is lost
         sd_pend  <= (apply ? 1'b0 : sd_pend) ^ sd_ev;
         sl_delta <= (apply ? 2'b00 : sl_delta) + {1'b0, sl_ev};
         case (state)
            IDLE: begin
               if (pend_any) begin
                  state  <= WAIT_VS;
                  to_cnt <= '0;
               end
            end
            WAIT_VS: begin
               if (apply) begin
                  scandoubler_disable_o <= scandoubler_disable_o ^ sd_pend;
                  sl_reg                <= sl_reg + sl_delta;
                  scanlines_o           <= (scandoubler_disable_o ^ sd_pend) ? SL_OFF : sl_reg + sl_delta;
                  if (sd_pend) begin
                     state     <= SETTLE;
                     frame_cnt <= 8'(SETTLE_FRAMES);
                     blank_o   <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            SETTLE: begin
               if (vs_ev) begin
                  if (frame_cnt <= 8'd1) begin
                     blank_o <= 1'b0;
                     to_cnt  <= '0;
                     state   <= pend_any ? WAIT_VS : IDLE;
                  end else begin
                     frame_cnt <= frame_cnt - 1'b1;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Core reset follows the request level, then holds for RST_HOLD cycles after it drops
   always_ff @(posedge clk_sys) begin
      if (reset || req_lvl) begin
         hold_cnt     <= 16'(RST_HOLD);
         core_reset_o <= 1'b1;
      end else if (hold_cnt != 16'd0) begin
         hold_cnt     <= hold_cnt - 1'b1;
         core_reset_o <= 1'b1;
      end else begin
         core_reset_o <= 1'b0;
      end
   end

endmodule
